// File: rtl/cbf_pkg.sv
// rtl/cbf_pkg.sv - shared clog2-derived width helpers
package cbf_pkg;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int phase_w(input int dsr);
        return $clog2(dsr) + 1;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - generic first-word-fall-through FIFO with occupancy level
module sample_fifo
    import cbf_pkg::*;
#(
    parameter int DataWidth = 16,
    parameter int Depth     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic [DataWidth-1:0]        wdata,
    output logic [DataWidth-1:0]        rdata,
    output logic [level_w(Depth)-1:0]   level,
    output logic                        full,
    output logic                        empty
);

    localparam int PtrW   = ptr_w(Depth);
    localparam int LevelW = level_w(Depth);

    logic [DataWidth-1:0] mem [Depth];
    logic [PtrW-1:0]      wr_ptr;
    logic [PtrW-1:0]      rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full  = (level == LevelW'(Depth));
    assign empty = (level == '0);

    // A push into a full FIFO only lands when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage is not reset, so the head reads as zero while nothing is buffered.
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/sample_decimator.sv
// rtl/sample_decimator.sv - keeps every DSR-th valid filter sample into an FWFT FIFO
module sample_decimator
    import cbf_pkg::*;
#(
    parameter int DataWidth = 16,
    parameter int DSR       = 4,
    parameter int Depth     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DataWidth-1:0]        in_data,
    input  logic                        in_valid,
    input  logic                        out_ready,
    output logic [DataWidth-1:0]        out_data,
    output logic                        out_valid,
    output logic                        overflow,
    output logic [level_w(Depth)-1:0]   level
);

    localparam int PhaseW = phase_w(DSR);

    logic [PhaseW-1:0] phase;
    logic              keep;
    logic              pop;
    logic              full;
    logic              empty;

    assign keep      = in_valid && (phase == '0);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    // Phase sits at zero while invalid so the first valid sample of every run is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
        end else if (!in_valid || (phase == PhaseW'(DSR - 1))) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (keep && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    sample_fifo #(
        .DataWidth (DataWidth),
        .Depth     (Depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (keep),
        .pop   (pop),
        .wdata (in_data),
        .rdata (out_data),
        .level (level),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_sample_decimator.sv
// tb/tb_sample_decimator.sv - directed self-checking bench for sample_decimator
module tb_sample_decimator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic [15:0] d4_data;
    logic        d4_valid;
    logic        d4_ovf;
    logic [2:0]  d4_level;
    logic [15:0] d1_data;
    logic        d1_valid;
    logic        d1_ovf;
    logic [2:0]  d1_level;

    int samp = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sample_decimator #(.DataWidth(16), .DSR(4), .Depth(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .out_data  (d4_data),
        .out_valid (d4_valid),
        .overflow  (d4_ovf),
        .level     (d4_level)
    );

    sample_decimator #(.DataWidth(16), .DSR(1), .Depth(4)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .out_data  (d1_data),
        .out_valid (d1_valid),
        .overflow  (d1_ovf),
        .level     (d1_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; afterwards sample index samp is on in_data.
    task automatic tick();
        @(posedge clk);
        #1;
        samp++;
        in_data = 16'(samp);
    endtask

    task automatic tick_to(input int n);
        while (samp < n) tick();
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        rst = 1'b0;
        #2;
        chk("rst_valid", 32'(d4_valid), 32'd0);
        chk("rst_level", 32'(d4_level), 32'd0);
        chk("rst_ovf",   32'(d4_ovf),   32'd0);
        chk("rst_data",  32'(d4_data),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        samp = 0;
        in_data = '0;
    endtask

    task automatic run_basic();
        out_ready = 1'b1;
        in_valid = 1'b0;
        tick_to(10);
        in_valid = 1'b1;
        tick();
        chk("basic_c11_valid", 32'(d4_valid), 32'd1);
        chk("basic_c11_data",  32'(d4_data),  32'd10);
        chk("basic_c11_level", 32'(d4_level), 32'd1);
        chk("dsr1_c11_data",   32'(d1_data),  32'd10);
        chk("dsr1_c11_valid",  32'(d1_valid), 32'd1);
        tick();
        chk("basic_c12_valid", 32'(d4_valid), 32'd0);
        chk("basic_c12_level", 32'(d4_level), 32'd0);
        chk("dsr1_c12_data",   32'(d1_data),  32'd11);
        while (samp < 15) begin
            tick();
            chk("dsr1_stream_data",  32'(d1_data),  32'(samp - 1));
            chk("dsr1_stream_level", 32'(d1_level), 32'd1);
        end
        chk("basic_c15_valid", 32'(d4_valid), 32'd1);
        chk("basic_c15_data",  32'(d4_data),  32'd14);
        tick_to(19);
        chk("basic_c19_data",  32'(d4_data),  32'd18);
        chk("basic_c19_ovf",   32'(d4_ovf),   32'd0);
        chk("dsr1_ovf",        32'(d1_ovf),   32'd0);
    endtask

    initial begin
        #1;
        apply_reset();
        run_basic();

        // Backpressure, overflow, drain, then refill to level 3 and reset asynchronously.
        apply_reset();
        out_ready = 1'b0;
        tick_to(10);
        in_valid = 1'b1;
        tick_to(23);
        chk("bp_c23_level", 32'(d4_level), 32'd4);
        chk("bp_c23_ovf",   32'(d4_ovf),   32'd0);
        tick_to(26);
        chk("bp_c26_ovf",   32'(d4_ovf),   32'd0);
        tick();
        chk("bp_c27_ovf",   32'(d4_ovf),   32'd1);
        chk("bp_c27_level", 32'(d4_level), 32'd4);
        chk("bp_c27_data",  32'(d4_data),  32'd10);
        out_ready = 1'b1;
        tick();
        chk("bp_c28_data",  32'(d4_data),  32'd14);
        chk("bp_c28_level", 32'(d4_level), 32'd3);
        tick();
        chk("bp_c29_data",  32'(d4_data),  32'd18);
        tick();
        chk("bp_c30_data",  32'(d4_data),  32'd22);
        chk("bp_c30_level", 32'(d4_level), 32'd1);
        tick();
        chk("bp_c31_data",  32'(d4_data),  32'd30);
        chk("bp_c31_level", 32'(d4_level), 32'd1);
        out_ready = 1'b0;
        tick_to(39);
        chk("bp_c39_level", 32'(d4_level), 32'd3);
        chk("bp_c39_ovf",   32'(d4_ovf),   32'd1);
        chk("bp_c39_data",  32'(d4_data),  32'd30);
        apply_reset();
        run_basic();

        // Pop coincides with a keep while full.
        apply_reset();
        out_ready = 1'b0;
        tick_to(10);
        in_valid = 1'b1;
        tick_to(23);
        chk("pp_c23_level", 32'(d4_level), 32'd4);
        tick_to(26);
        out_ready = 1'b1;
        chk("pp_c26_data",  32'(d4_data),  32'd10);
        tick();
        chk("pp_c27_level", 32'(d4_level), 32'd4);
        chk("pp_c27_ovf",   32'(d4_ovf),   32'd0);
        chk("pp_c27_data",  32'(d4_data),  32'd14);
        tick();
        chk("pp_c28_data",  32'(d4_data),  32'd18);
        chk("pp_c28_level", 32'(d4_level), 32'd3);
        tick();
        chk("pp_c29_data",  32'(d4_data),  32'd22);
        tick();
        chk("pp_c30_data",  32'(d4_data),  32'd26);
        chk("pp_c30_level", 32'(d4_level), 32'd1);
        tick();
        chk("pp_c31_data",  32'(d4_data),  32'd30);
        chk("pp_c31_ovf",   32'(d4_ovf),   32'd0);

        // in_valid drops for samples 15 and 16; grid re-aligns at 17.
        apply_reset();
        out_ready = 1'b0;
        tick_to(10);
        in_valid = 1'b1;
        tick_to(15);
        in_valid = 1'b0;
        tick_to(17);
        in_valid = 1'b1;
        tick_to(22);
        chk("gl_c22_level", 32'(d4_level), 32'd4);
        chk("gl_c22_data",  32'(d4_data),  32'd10);
        chk("gl_c22_ovf",   32'(d4_ovf),   32'd0);
        out_ready = 1'b1;
        tick();
        chk("gl_c23_data",  32'(d4_data),  32'd14);
        tick();
        chk("gl_c24_data",  32'(d4_data),  32'd17);
        tick();
        chk("gl_c25_data",  32'(d4_data),  32'd21);
        chk("gl_c25_level", 32'(d4_level), 32'd1);
        tick();
        chk("gl_c26_data",  32'(d4_data),  32'd25);
        chk("gl_c26_level", 32'(d4_level), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
